// File: rtl/div11_share_sched.sv
// Round-robin front end sharing one external pipelined divide-by-11 unit.
// Issue tags ride alongside the divider so the remainder can be rebuilt when the quotient returns.
module div11_share_sched #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ID_W      = 2,
   parameter int unsigned DIV_LAT   = 2,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*64-1:0] req_x,
   output logic [63:0]           div_x,
   input  logic [60:0]           div_q,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [60:0]           rsp_q,
   output logic [3:0]            rsp_r,
   output logic                  busy
);

   localparam int unsigned Q_W   = 61;
   localparam int unsigned R_W   = 4;
   localparam int unsigned RR_W  = $clog2(NUM_REQ);
   localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [RR_W-1:0]    rr_q, rr_d;
   logic [DIV_LAT-1:0] tag_v_q, tag_v_d;
   logic [ID_W-1:0]    tag_id_q  [DIV_LAT];
   logic [ID_W-1:0]    tag_id_d  [DIV_LAT];
   logic [R_W-1:0]     tag_xlo_q [DIV_LAT];
   logic [R_W-1:0]     tag_xlo_d [DIV_LAT];

   logic [ID_W-1:0]    mem_id_q [RSP_DEPTH];
   logic [ID_W-1:0]    mem_id_d [RSP_DEPTH];
   logic [Q_W-1:0]     mem_qt_q [RSP_DEPTH];
   logic [Q_W-1:0]     mem_qt_d [RSP_DEPTH];
   logic [R_W-1:0]     mem_r_q  [RSP_DEPTH];
   logic [R_W-1:0]     mem_r_d  [RSP_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [31:0]        used_c;
   logic               can_issue_c;
   logic               grant_v_c;
   logic [RR_W-1:0]    grant_id_c;
   logic [RR_W-1:0]    idx_c;
   logic               push_c;
   logic               pop_c;
   logic [7:0]         prod_c;
   logic [R_W-1:0]     rem_c;

   // Credit: queued entries plus in-flight tags must leave a free FIFO slot.
   always_comb begin
      used_c = 32'(cnt_q);
      for (int unsigned s = 0; s < DIV_LAT; s++) begin
         used_c = used_c + 32'(tag_v_q[s]);
      end
      can_issue_c = rst_n & (used_c < RSP_DEPTH);
   end

   // Round-robin search starting at the pointer, wrapping past NUM_REQ-1.
   always_comb begin
      grant_v_c  = 1'b0;
      grant_id_c = '0;
      idx_c      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx_c = RR_W'((32'(rr_q) + k) % NUM_REQ);
         if (can_issue_c && !grant_v_c && req_valid[idx_c]) begin
            grant_v_c  = 1'b1;
            grant_id_c = idx_c;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      div_x     = '0;
      rr_d      = rr_q;
      if (grant_v_c) begin
         req_ready[grant_id_c] = 1'b1;
         div_x = req_x[{grant_id_c, 6'b0} +: 64];
         rr_d  = (32'(grant_id_c) == NUM_REQ - 1) ? '0 : grant_id_c + RR_W'(1);
      end
   end

   // Tag pipe shadows the divider latency.
   always_comb begin
      tag_v_d   = tag_v_q;
      tag_id_d  = tag_id_q;
      tag_xlo_d = tag_xlo_q;
      for (int unsigned s = DIV_LAT - 1; s > 0; s--) begin
         tag_v_d[s]   = tag_v_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
         tag_xlo_d[s] = tag_xlo_q[s-1];
      end
      tag_v_d[0]   = grant_v_c;
      tag_id_d[0]  = ID_W'(grant_id_c);
      tag_xlo_d[0] = div_x[3:0];
   end

   // x mod 11 < 16, so only the low nibble of x - 11*q is needed.
   always_comb begin
      prod_c = {4'b0, div_q[3:0]} * 8'd11;
      rem_c  = tag_xlo_q[DIV_LAT-1] - prod_c[3:0];
   end

   assign push_c = tag_v_q[DIV_LAT-1];
   assign pop_c  = rsp_valid & rsp_ready;

   always_comb begin
      mem_id_d = mem_id_q;
      mem_qt_d = mem_qt_q;
      mem_r_d  = mem_r_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_c) begin
         mem_id_d[wr_ptr_q] = tag_id_q[DIV_LAT-1];
         mem_qt_d[wr_ptr_q] = div_q;
         mem_r_d[wr_ptr_q]  = rem_c;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   assign rsp_valid = (cnt_q != '0);
   assign busy      = (|tag_v_q) | rsp_valid;

   always_comb begin
      rsp_id = '0;
      rsp_q  = '0;
      rsp_r  = '0;
      if (rsp_valid) begin
         rsp_id = mem_id_q[rd_ptr_q];
         rsp_q  = mem_qt_q[rd_ptr_q];
         rsp_r  = mem_r_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= '0;
         tag_v_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int unsigned s = 0; s < DIV_LAT; s++) begin
            tag_id_q[s]  <= '0;
            tag_xlo_q[s] <= '0;
         end
         for (int unsigned e = 0; e < RSP_DEPTH; e++) begin
            mem_id_q[e] <= '0;
            mem_qt_q[e] <= '0;
            mem_r_q[e]  <= '0;
         end
      end else begin
         rr_q      <= rr_d;
         tag_v_q   <= tag_v_d;
         tag_id_q  <= tag_id_d;
         tag_xlo_q <= tag_xlo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         mem_id_q  <= mem_id_d;
         mem_qt_q  <= mem_qt_d;
         mem_r_q   <= mem_r_d;
      end
   end

endmodule

// File: tb/tb_div11_share_sched.sv
// Scoreboard bench for div11_share_sched with a behavioural divide-by-11 pipeline.
module tb_div11_share_sched;

   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned ID_W      = 2;
   localparam int unsigned DIV_LAT   = 2;
   localparam int unsigned RSP_DEPTH = 4;

   typedef struct {
      logic [63:0] x;
      logic [60:0] q;
      logic [3:0]  r;
   } vec_t;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [60:0]     q;
      logic [3:0]      r;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*64-1:0] req_x;
   logic [63:0]           div_x;
   logic [60:0]           div_q;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [60:0]           rsp_q;
   logic [3:0]            rsp_r;
   logic                  busy;

   vec_t pend [NUM_REQ][$];
   exp_t sb [$];
   int   grant_log [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   issued;

   always #5 clk = ~clk;

   div11_share_sched #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIV_LAT(DIV_LAT), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
      .div_x(div_x), .div_q(div_q),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
      .busy(busy)
   );

   // External divider: not reset, so stale quotients after reset must be ignored by the DUT.
   logic [60:0] dq_pipe [DIV_LAT];
   always @(posedge clk) begin
      dq_pipe[0] <= 61'(div_x / 64'd11);
      for (int i = 1; i < DIV_LAT; i++) dq_pipe[i] <= dq_pipe[i-1];
   end
   assign div_q = dq_pipe[DIV_LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input int id, input logic [63:0] x, input logic [60:0] q, input logic [3:0] r);
      vec_t v;
      v.x = x; v.q = q; v.r = r;
      pend[id].push_back(v);
   endtask

   function automatic bit pend_empty();
      for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One cycle: drive after negedge, record acceptances before the posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]       = (pend[i].size() != 0);
         req_x[64*i +: 64]  = req_valid[i] ? pend[i][0].x : 64'd0;
      end
      #2;
      issued = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            e.id = ID_W'(i); e.q = pend[i][0].q; e.r = pend[i][0].r;
            sb.push_back(e);
            grant_log.push_back(i);
            void'(pend[i].pop_front());
            issued++;
         end
      end
   endtask

   task automatic drain(input int limit);
      bit done = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < limit && !done; c++) begin
         step();
         if (pend_empty() && sb.size() == 0 && !busy) done = 1'b1;
      end
      chk("drain_complete", 64'(done), 64'd1);
   endtask

   task automatic load_fair();
      add(0, 64'd23, 61'd2, 4'd1);         add(1, 64'd45, 61'd4, 4'd1);
      add(2, 64'd77, 61'd7, 4'd0);         add(3, 64'd1234567, 61'd112233, 4'd4);
      add(0, 64'd1000, 61'd90, 4'd10);     add(1, 64'd12345, 61'd1122, 4'd3);
      add(2, 64'd65535, 61'd5957, 4'd8);   add(3, 64'd99, 61'd9, 4'd0);
   endtask

   // Response monitor: compares whatever the DUT hands over against issue order.
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_unexpected: got id %0d q %0d r %0d expected no response", rsp_id, rsp_q, rsp_r);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_q", 64'(rsp_q), 64'(e.q));
            chk("rsp_r", 64'(rsp_r), 64'(e.r));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int total;
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = '1;
      req_x     = {NUM_REQ{64'd55}};
      #12;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_div_x", div_x, 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_q", 64'(rsp_q), 64'd0);
      req_valid = '0;
      req_x     = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Fairness: all requesters busy, one grant per cycle in rotating order.
      rsp_ready = 1'b1;
      load_fair();
      grant_log.delete();
      for (int c = 0; c < 8; c++) begin
         step();
         chk("fair_one_per_cycle", 64'(issued), 64'd1);
      end
      for (int i = 0; i < 8; i++) chk("fair_order", 64'(grant_log[i]), 64'(i % 4));
      drain(40);

      // Single request and latency.
      rsp_ready = 1'b0;
      add(2, 64'd100, 61'd9, 4'd1);
      step();
      chk("single_ready", 64'(req_ready), 64'b0100);
      chk("single_div_x", div_x, 64'd100);
      step();
      chk("single_ready_once", 64'(req_ready), 64'd0);
      chk("lat_edge1_valid", 64'(rsp_valid), 64'd0);
      chk("lat_busy", 64'(busy), 64'd1);
      step();
      chk("lat_edge2_valid", 64'(rsp_valid), 64'd0);
      step();
      chk("lat_edge3_valid", 64'(rsp_valid), 64'd1);
      drain(20);

      // Extremes.
      add(1, 64'd0, 61'd0, 4'd0);
      add(1, 64'd10, 61'd0, 4'd10);
      add(1, 64'hFFFF_FFFF_FFFF_FFFF, 61'd1676976733973595601, 4'd4);
      drain(30);

      // Backpressure: credit stops issue at RSP_DEPTH outstanding.
      rsp_ready = 1'b0;
      load_fair();
      load_fair();
      total = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         total += issued;
      end
      chk("bp_issue_count", 64'(total), 64'd4);
      chk("bp_ready_zero", 64'(req_ready), 64'd0);
      chk("bp_fifo_valid", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      step();
      chk("bp_refill_after_pop", 64'(issued), 64'd1);
      rsp_ready = 1'b0;
      step();
      chk("bp_blocked_again", 64'(issued), 64'd0);
      drain(80);

      // Sustained push with pop once the FIFO holds entries.
      rsp_ready = 1'b0;
      add(3, 64'd11, 61'd1, 4'd0);      add(3, 64'd12, 61'd1, 4'd1);
      add(3, 64'd200, 61'd18, 4'd2);    add(3, 64'd255, 61'd23, 4'd2);
      add(3, 64'd4096, 61'd372, 4'd4);  add(3, 64'd7, 61'd0, 4'd7);
      add(3, 64'd33, 61'd3, 4'd0);      add(3, 64'd500, 61'd45, 4'd5);
      add(3, 64'd1023, 61'd93, 4'd0);   add(3, 64'd777, 61'd70, 4'd7);
      for (int c = 0; c < 5; c++) step();
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         chk("steady_valid", 64'(rsp_valid), 64'd1);
      end
      drain(40);

      // Reset with two ops in flight and one queued.
      rsp_ready = 1'b0;
      add(0, 64'd121, 61'd11, 4'd0);  add(0, 64'd5, 61'd0, 4'd5);
      add(0, 64'd56, 61'd5, 4'd1);    add(0, 64'd88, 61'd8, 4'd0);
      step(); step(); step();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
      chk("mid_rst_div_x", div_x, 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("mid_rst_rsp_q", 64'(rsp_q), 64'd0);
      chk("mid_rst_rsp_r", 64'(rsp_r), 64'd0);
      pend[0].delete();
      sb.delete();
      req_valid = '0;
      req_x     = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("post_rst_no_stale", 64'(rsp_valid), 64'd0);
      end
      add(1, 64'd22, 61'd2, 4'd0);
      drain(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
